// File: rtl/btb_predictor.sv
// N-way set-associative branch target buffer with per-set round-robin replacement
// and a circular return address stack. Lookup is combinational; update is registered.
module btb_way_match #(
  parameter int TAG_W = 26
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] entry_tag,
  input  logic [TAG_W-1:0] probe_tag,
  output logic             hit
);
  assign hit = valid && (entry_tag == probe_tag);
endmodule

module btb_predictor #(
  parameter int SETS      = 16,
  parameter int WAYS      = 2,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_ret,
  input  logic        ras_push,
  input  logic [31:0] ras_push_addr,
  input  logic        ras_pop,
  output logic [31:0] ras_top,
  output logic        ras_empty
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SP_W:0]    RAS_FULL = (SP_W + 1)'(RAS_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_ret;
    logic [CNT_W-1:0] cnt;
  } btb_entry_t;

  btb_entry_t       tbl    [SETS][WAYS];
  logic [WAY_W-1:0] rr_ptr [SETS];

  logic [IDX_W-1:0] l_set, u_set;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [WAYS-1:0]  l_hit_vec, u_hit_vec;
  logic             unused_pc_lsbs;

  assign l_set = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_set = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way_match #(.TAG_W(TAG_W)) u_lmatch (
      .valid(tbl[l_set][w].valid), .entry_tag(tbl[l_set][w].tag),
      .probe_tag(l_tag), .hit(l_hit_vec[w]));
    btb_way_match #(.TAG_W(TAG_W)) u_umatch (
      .valid(tbl[u_set][w].valid), .entry_tag(tbl[u_set][w].tag),
      .probe_tag(u_tag), .hit(u_hit_vec[w]));
  end

  // ---------------- lookup ----------------
  btb_entry_t l_ent;
  logic       l_hit;

  always_comb begin
    l_ent = '0;
    for (int w = 0; w < WAYS; w++)
      if (l_hit_vec[w]) l_ent = tbl[l_set][w];
  end

  assign l_hit = |l_hit_vec;

  always_comb begin
    pred_valid  = 1'b0;
    pred_target = lookup_pc + 32'd4;
    if (l_hit && l_ent.is_ret && !ras_empty) begin
      pred_valid  = 1'b1;
      pred_target = ras_top;
    end else if (l_hit && !l_ent.is_ret && l_ent.cnt[CNT_W-1]) begin
      pred_valid  = 1'b1;
      pred_target = l_ent.target;
    end
  end

  // ---------------- update ----------------
  logic             u_hit, any_inv, wr_en, evict;
  logic [WAY_W-1:0] u_way, inv_way, wr_way;
  btb_entry_t       nxt;

  assign u_hit = |u_hit_vec;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    u_way   = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (u_hit_vec[w]) u_way = WAY_W'(w);
      if (!tbl[u_set][w].valid) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign wr_way = u_hit ? u_way : (any_inv ? inv_way : rr_ptr[u_set]);
  assign wr_en  = upd_valid && (u_hit || upd_taken);
  assign evict  = upd_valid && !u_hit && upd_taken && !any_inv;

  always_comb begin
    nxt = tbl[u_set][u_way];
    if (u_hit) begin
      if (upd_taken) begin
        if (nxt.target != upd_target) begin
          nxt.target = upd_target;
          nxt.cnt    = CNT_WEAK;
        end else if (nxt.cnt != CNT_MAX) begin
          nxt.cnt = nxt.cnt + 1'b1;
        end
      end else if (nxt.cnt != '0) begin
        nxt.cnt = nxt.cnt - 1'b1;
      end
      nxt.is_ret = upd_is_ret;
    end else begin
      nxt.valid  = 1'b1;
      nxt.tag    = u_tag;
      nxt.target = upd_target;
      nxt.is_ret = upd_is_ret;
      nxt.cnt    = CNT_WEAK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tbl[s][w].valid <= 1'b0;
          tbl[s][w].cnt   <= '0;
        end
      end
    end else begin
      if (wr_en) tbl[u_set][wr_way] <= nxt;
      if (evict && WAYS > 1) rr_ptr[u_set] <= rr_ptr[u_set] + 1'b1;
    end
  end

  // ---------------- return address stack ----------------
  logic [31:0]   ras_buf [RAS_DEPTH];
  logic [SP_W-1:0] sp, sp_m1;
  logic [SP_W:0]   cnt_ras;

  assign sp_m1     = sp - 1'b1;
  assign ras_empty = (cnt_ras == '0);
  assign ras_top   = ras_empty ? 32'd0 : ras_buf[sp_m1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      cnt_ras <= '0;
    end else if (ras_push && ras_pop && !ras_empty) begin
      ras_buf[sp_m1] <= ras_push_addr;
    end else if (ras_push) begin
      // When full the write lands on the oldest slot, dropping it.
      ras_buf[sp] <= ras_push_addr;
      sp          <= sp + 1'b1;
      if (cnt_ras != RAS_FULL) cnt_ras <= cnt_ras + 1'b1;
    end else if (ras_pop && !ras_empty) begin
      sp      <= sp_m1;
      cnt_ras <= cnt_ras - 1'b1;
    end
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised successor to the fetch-stage direct-mapped BTB. It provides an N-way set-associative branch target buffer with configurable counter width and per-set round-robin replacement, plus a return address stack (RAS) for function returns. The fetch stage drives the lookup port combinationally from the current PC. The EX stage drives the update port when a control-transfer instruction resolves.

Parameters:
SETS, 16, number of sets; power of 2, >=2; IDX_W = log2(SETS)
WAYS, 2, ways per set; power of 2, >=1
CNT_W, 2, saturating counter width; >=1
RAS_DEPTH, 4, return address stack entries; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lookup_pc  in  32  PC of the instruction being fetched
pred_valid  out  1  predict redirect this cycle
pred_target  out  32  predicted next PC (lookup_pc+4 when pred_valid=0)
upd_valid  in  1  update strobe from EX
upd_pc  in  32  PC of the resolved instruction
upd_taken  in  1  resolved direction
upd_target  in  32  resolved target (valid when upd_taken=1)
upd_is_ret  in  1  resolved instruction is a return (jalr x0, ra)
ras_push  in  1  push return address (call fetched/decoded)
ras_push_addr  in  32  address to push (call PC+4)
ras_pop  in  1  pop (return fetched/decoded)
ras_top  out  32  current top of stack
ras_empty  out  1  stack holds no entries

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Address split:
  - set = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2] (30-IDX_W bits)
- Entry fields: valid, tag, target[31:0], is_ret, cnt[CNT_W-1:0].
- Lookup (combinational, zero latency):
  - hit = any way in the set with valid and tag match. At most one way matches by construction.
  - On a hit with is_ret=1 and ras_empty=0: pred_valid=1, pred_target=ras_top.
  - On a hit with is_ret=0 and cnt[CNT_W-1]=1: pred_valid=1, pred_target=target.
  - Otherwise: pred_valid=0, pred_target=lookup_pc+4, mod 2^32.
- Update timing: registered on the clk edge where upd_valid=1. The result is visible to lookup from the next cycle. A lookup in the same cycle sees the old contents.
- Update on a hit:
  - taken and target differs: target <= upd_target, cnt <= 2^(CNT_W-1) (weakly taken).
  - taken and target equal: cnt saturating +1.
  - not taken: cnt saturating -1. Target unchanged.
  - is_ret <= upd_is_ret.
- Update on a miss:
  - not taken: no allocation, no state change.
  - taken: allocate the lowest-index invalid way. If no way is invalid, allocate way rr_ptr[set], then rr_ptr[set] <= (rr_ptr+1) mod WAYS.
  - New entry fields: valid=1, tag, target=upd_target, is_ret=upd_is_ret, cnt=2^(CNT_W-1).
  - rr_ptr advances only on eviction.
- RAS structure: circular buffer with top pointer sp and occupancy count cnt_ras (0..RAS_DEPTH).
  - ras_top = buf[sp-1]. Returns 0 when empty.
  - ras_empty = (cnt_ras==0).
- RAS operations:
  - push only: buf[sp] <= addr, sp++ (wraps). cnt_ras saturates at RAS_DEPTH; when full, the oldest entry is silently overwritten.
  - pop only: if not empty, sp--, cnt_ras--. If empty, no-op.
  - push and pop in the same cycle: buf[sp-1] <= addr; sp and cnt_ras unchanged. When empty, behaves as push only.
- Reset: all valid <= 0, cnt <= 0, rr_ptr <= 0, sp <= 0, cnt_ras <= 0.
  - Outputs after reset: pred_valid=0, pred_target=lookup_pc+4, ras_empty=1, ras_top=0.
  - rst asserted in the same cycle as upd_valid or push: reset wins.

Test Plan:
- Reset, then lookup 0x8000_0010 -> pred_valid=0, pred_target=0x8000_0014, ras_empty=1.
- Update pc=0x100, taken, target=0x200; next cycle lookup 0x100 -> pred_valid=1, pred_target=0x200. Then two not-taken updates -> cnt 2->1->0, pred_valid=0.
- WAYS=2, SETS=16: taken updates to 0x100, 0x140, 0x180 (same set 0):
  - 0x100 -> way0, 0x140 -> way1, 0x180 evicts way0 (rr_ptr 0->1).
  - Then lookup 0x100 misses; 0x140 and 0x180 hit.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_top=0x50. After four pops the tops are 0x40, 0x30, 0x20, and the stack is empty; a 5th pop is a no-op with ras_empty=1.
- Update pc=0x300, taken, is_ret=1; push 0x404; lookup 0x300 -> pred_target=0x404. Pop to empty -> pred_valid=0.
- Same-cycle push 0x11 and pop with two entries [0xA, 0xB] -> stack [0xA, 0x11]. Update plus lookup on the same set in one cycle -> old prediction this cycle, new prediction next cycle.
